// File: rtl/truth_table_sweeper_if.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper_if
// Bundles every non-clock signal between the truth-table sweeper, the
// test/config controller that starts it and the 3-input gate under test.
//
// Signals
//   start     controller -> sweeper   request a sweep (accepted only in IDLE)
//   abort     controller -> sweeper   cancel the current sweep
//   expected  controller -> sweeper   expected table, MSB = row 000
//   dut_out   gate       -> sweeper   output of the gate under test
//   dut_in1/2/3 sweeper  -> gate      row drive, dut_in1 = row MSB
//   busy, done, pass, measured, mismatch   sweeper -> controller status
//
// Modports
//   slave  : the sweeper itself
//   master : the environment around it (controller plus gate)
// ---------------------------------------------------------------------------
interface truth_table_sweeper_if;
    logic       start;
    logic       abort;
    logic [7:0] expected;
    logic       dut_out;
    logic       dut_in1;
    logic       dut_in2;
    logic       dut_in3;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] measured;
    logic [7:0] mismatch;

    modport slave (
        input  start, abort, expected, dut_out,
        output dut_in1, dut_in2, dut_in3, busy, done, pass, measured, mismatch
    );

    modport master (
        output start, abort, expected, dut_out,
        input  dut_in1, dut_in2, dut_in3, busy, done, pass, measured, mismatch
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
// Drives the 8 input rows 000..111 into a 3-input gate, holds each row for
// SETTLE_CYCLES clocks, samples the gate output on the last cycle of the row
// and, after row 111, compares the measured table with the expected table
// captured at start.
//
// Parameters
//   SETTLE_CYCLES  cycles each row is held before sampling (>= 1)
//   CNT_W          settle counter width, 2**CNT_W >= SETTLE_CYCLES
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, returns everything to 0 / IDLE
//   bus    truth_table_sweeper_if.slave (start/abort/expected/dut_out in,
//          dut_in1..3/busy/done/pass/measured/mismatch out)
//
// Timing: busy rises the cycle after start is accepted; a sweep takes
// 8*SETTLE_CYCLES RUN cycles plus one FIN cycle; done/pass/mismatch appear
// together in the first IDLE cycle, where a new start is already accepted.
// ---------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    truth_table_sweeper_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    state_t           state_r;
    logic [2:0]       row_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       exp_r;
    logic [7:0]       measured_r;
    logic [7:0]       mismatch_r;
    logic             pass_r;
    logic             done_r;
    logic             busy_r;
    logic [2:0]       dut_in_r;

    // Sweep sequencer: row/settle counting, sampling, compare and all outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            row_r      <= 3'd0;
            cnt_r      <= {CNT_W{1'b0}};
            exp_r      <= 8'h00;
            measured_r <= 8'h00;
            mismatch_r <= 8'h00;
            pass_r     <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            dut_in_r   <= 3'd0;
        end else begin
            // done is a single-cycle pulse; only FIN raises it.
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // abort beats a simultaneous start; otherwise results are held.
                    if (bus.start && !bus.abort) begin
                        state_r    <= RUN;
                        row_r      <= 3'd0;
                        cnt_r      <= {CNT_W{1'b0}};
                        exp_r      <= bus.expected;
                        measured_r <= 8'h00;
                        mismatch_r <= 8'h00;
                        pass_r     <= 1'b0;
                        busy_r     <= 1'b1;
                        dut_in_r   <= 3'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        // measured keeps its partial content; it is not meaningful.
                        state_r  <= IDLE;
                        busy_r   <= 1'b0;
                        pass_r   <= 1'b0;
                        dut_in_r <= 3'd0;
                    end else if (cnt_r == CNT_LAST) begin
                        // Last settle cycle of the row: capture; MSB holds row 000.
                        measured_r[3'd7 - row_r] <= bus.dut_out;
                        cnt_r <= {CNT_W{1'b0}};
                        if (row_r == 3'd7) begin
                            state_r <= FIN;
                        end else begin
                            row_r    <= row_r + 3'd1;
                            dut_in_r <= row_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                FIN: begin
                    state_r  <= IDLE;
                    busy_r   <= 1'b0;
                    dut_in_r <= 3'd0;
                    if (bus.abort) begin
                        pass_r <= 1'b0;
                    end else begin
                        mismatch_r <= measured_r ^ exp_r;
                        pass_r     <= (measured_r == exp_r);
                        done_r     <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean idle.
                    state_r  <= IDLE;
                    busy_r   <= 1'b0;
                    pass_r   <= 1'b0;
                    dut_in_r <= 3'd0;
                end
            endcase
        end
    end

    assign bus.dut_in1  = dut_in_r[2];
    assign bus.dut_in2  = dut_in_r[1];
    assign bus.dut_in3  = dut_in_r[0];
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.pass     = pass_r;
    assign bus.measured = measured_r;
    assign bus.mismatch = mismatch_r;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// tb_truth_table_sweeper
// Two sweepers share one clock: SETTLE_CYCLES=4 (main) and SETTLE_CYCLES=1.
// Each drives a modelled gate whose truth table is a byte (MSB = row 000).
// Reference: a correct sweep measures exactly the gate's table, mismatch is
// table ^ expected and pass is table == expected; row k/S is on the inputs
// during the k-th RUN cycle.
// ---------------------------------------------------------------------------
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    truth_table_sweeper_if b4();
    truth_table_sweeper_if b1();

    logic [7:0] gate4;
    logic [7:0] gate1;

    assign b4.dut_out = gate4[3'd7 - {b4.dut_in1, b4.dut_in2, b4.dut_in3}];
    assign b1.dut_out = gate1[3'd7 - {b1.dut_in1, b1.dut_in2, b1.dut_in3}];

    truth_table_sweeper #(.SETTLE_CYCLES(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .reset(reset), .bus(b4)
    );
    truth_table_sweeper #(.SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .reset(reset), .bus(b1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] gate;
        logic [7:0] exp;
        logic [7:0] meas;
        logic [7:0] mis;
        logic       pass;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [2:0] din4();
        return {b4.dut_in1, b4.dut_in2, b4.dut_in3};
    endfunction

    function automatic logic [2:0] din1();
        return {b1.dut_in1, b1.dut_in2, b1.dut_in3};
    endfunction

    task automatic check1(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, act, req);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %02h, want %02h", name, act, req);
        end
    endtask

    task automatic checki(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start4(input logic [7:0] g, input logic [7:0] e);
        gate4 = g;
        b4.expected = e;
        b4.start = 1'b1;
        tick();
        b4.start = 1'b0;
    endtask

    // Runs until busy drops (bounded); counts busy cycles and sequencing errors.
    task automatic wait_idle4(input int midk, input bit scramble,
                              output int nbusy, output int seqbad);
        nbusy  = 0;
        seqbad = 0;
        for (int k = 0; k < 200; k++) begin
            if (b4.busy !== 1'b1) break;
            if (k < 32 && din4() != 3'(k / 4)) seqbad++;
            if (b4.done !== 1'b0) seqbad++;
            nbusy++;
            b4.start = (k == midk);
            if (scramble) b4.expected = 8'($urandom);
            tick();
        end
        b4.start = 1'b0;
    endtask

    task automatic check_done4(input string tag, input logic [7:0] meas,
                               input logic [7:0] mis, input logic p);
        check1({tag, "_done"}, b4.done, 1'b1);
        check8({tag, "_measured"}, b4.measured, meas);
        check8({tag, "_mismatch"}, b4.mismatch, mis);
        check1({tag, "_pass"}, b4.pass, p);
        check8({tag, "_dut_in"}, {5'd0, din4()}, 8'd0);
    endtask

    task automatic full_sweep4(input string tag, input logic [7:0] g, input logic [7:0] e,
                               input logic [7:0] meas, input logic [7:0] mis,
                               input logic p, input bit scramble);
        int nb;
        int sb;
        start4(g, e);
        wait_idle4(-1, scramble, nb, sb);
        checki({tag, "_busy_len"}, nb, 33);
        checki({tag, "_row_seq"}, sb, 0);
        check_done4(tag, meas, mis, p);
        tick();
        check1({tag, "_done_once"}, b4.done, 1'b0);
    endtask

    initial begin
        int nb;
        int sb;
        logic [7:0] g;
        logic [7:0] e;

        reset = 1'b1;
        b4.start = 1'b0; b4.abort = 1'b0; b4.expected = 8'h00;
        b1.start = 1'b0; b1.abort = 1'b0; b1.expected = 8'h00;
        gate4 = 8'h00;
        gate1 = 8'h00;
        #2;
        check1("rst_busy", b4.busy, 1'b0);
        check1("rst_done", b4.done, 1'b0);
        check1("rst_pass", b4.pass, 1'b0);
        check8("rst_measured", b4.measured, 8'h00);
        check8("rst_mismatch", b4.mismatch, 8'h00);
        check8("rst_dut_in", {5'd0, din4()}, 8'd0);
        tick();
        reset = 1'b0;
        tick();

        // Directed table: B9 gate, stuck-at-0, 96 gate, FF vs FE, 5A vs A5.
        vecs[0] = '{gate: 8'hB9, exp: 8'hB9, meas: 8'hB9, mis: 8'h00, pass: 1'b1};
        vecs[1] = '{gate: 8'h00, exp: 8'hB9, meas: 8'h00, mis: 8'hB9, pass: 1'b0};
        vecs[2] = '{gate: 8'h96, exp: 8'h96, meas: 8'h96, mis: 8'h00, pass: 1'b1};
        vecs[3] = '{gate: 8'hFF, exp: 8'hFE, meas: 8'hFF, mis: 8'h01, pass: 1'b0};
        vecs[4] = '{gate: 8'h5A, exp: 8'hA5, meas: 8'h5A, mis: 8'hFF, pass: 1'b0};
        for (int i = 0; i < 5; i++) begin
            full_sweep4("vec", vecs[i].gate, vecs[i].exp, vecs[i].meas, vecs[i].mis,
                        vecs[i].pass, 1'b0);
        end

        // Abort alone, and start together with abort, in IDLE: results held.
        full_sweep4("pre_idle", 8'hB9, 8'hB9, 8'hB9, 8'h00, 1'b1, 1'b0);
        b4.abort = 1'b1;
        tick();
        b4.abort = 1'b0;
        check1("idle_abort_pass", b4.pass, 1'b1);
        check8("idle_abort_meas", b4.measured, 8'hB9);
        b4.start = 1'b1;
        b4.abort = 1'b1;
        tick();
        b4.start = 1'b0;
        b4.abort = 1'b0;
        check1("start_abort_busy", b4.busy, 1'b0);
        check1("start_abort_pass", b4.pass, 1'b1);

        // Abort mid-sweep.
        start4(8'hB9, 8'hB9);
        repeat (10) tick();
        b4.abort = 1'b1;
        tick();
        b4.abort = 1'b0;
        check1("abort_busy", b4.busy, 1'b0);
        check1("abort_done", b4.done, 1'b0);
        check1("abort_pass", b4.pass, 1'b0);
        check8("abort_dut_in", {5'd0, din4()}, 8'd0);
        tick();
        check1("abort_no_done", b4.done, 1'b0);

        // Mid-sweep start ignored, then back-to-back start in the done cycle.
        start4(8'hB9, 8'hB9);
        wait_idle4(5, 1'b0, nb, sb);
        checki("b2b_first_len", nb, 33);
        checki("b2b_first_seq", sb, 0);
        check_done4("b2b_first", 8'hB9, 8'h00, 1'b1);
        start4(8'h96, 8'h96);
        check1("b2b_no_gap", b4.busy, 1'b1);
        wait_idle4(-1, 1'b0, nb, sb);
        checki("b2b_second_len", nb, 33);
        check_done4("b2b_second", 8'h96, 8'h00, 1'b1);
        tick();
        check1("b2b_no_queue", b4.busy, 1'b0);

        // Asynchronous reset between edges during row 5.
        start4(8'hB9, 8'hB9);
        repeat (21) tick();
        check8("row5_dut_in", {5'd0, din4()}, 8'd5);
        #2;
        reset = 1'b1;
        #1;
        check1("areset_busy", b4.busy, 1'b0);
        check8("areset_measured", b4.measured, 8'h00);
        check8("areset_dut_in", {5'd0, din4()}, 8'd0);
        check1("areset_pass", b4.pass, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check1("post_reset_idle", b4.busy, 1'b0);
        full_sweep4("post_reset", 8'hB9, 8'hB9, 8'hB9, 8'h00, 1'b1, 1'b0);

        // Random gates; expected is scrambled during the sweep to prove capture.
        for (int i = 0; i < 16; i++) begin
            g = 8'($urandom);
            e = ($urandom_range(0, 1) == 0) ? g : 8'($urandom);
            full_sweep4("rand", g, e, g, g ^ e, (g == e), 1'b1);
        end

        // SETTLE_CYCLES=1 build: one cycle per row.
        gate1 = 8'hFF;
        b1.expected = 8'hFE;
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        nb = 0;
        sb = 0;
        for (int k = 0; k < 100; k++) begin
            if (b1.busy !== 1'b1) break;
            if (k < 8 && din1() != 3'(k)) sb++;
            nb++;
            tick();
        end
        checki("s1_busy_len", nb, 9);
        checki("s1_row_seq", sb, 0);
        check1("s1_done", b1.done, 1'b1);
        check8("s1_measured", b1.measured, 8'hFF);
        check8("s1_mismatch", b1.mismatch, 8'h01);
        check1("s1_pass", b1.pass, 1'b0);
        tick();
        check1("s1_done_once", b1.done, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
